// File: rtl/uart_debug_loader.sv
// uart_debug_loader: 8N1 UART receiver that decodes host frames into debug-port word writes.
module uart_debug_loader #(
    parameter int CLKS_PER_BIT = 174,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_i,
    output logic        debug_o,
    output logic [31:0] debug_addr_o,
    output logic [31:0] debug_data_o,
    output logic        debug_imem_o,
    output logic        debug_we_o,
    output logic        rx_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO      = TW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {P_CMD, P_ADDR, P_DATA} p_state_t;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic byte_valid, frame_err;
    p_state_t p_state_q, p_state_d;
    logic [1:0] idx_q, idx_d;
    logic [31:0] abuf_q, abuf_d, dbuf_q, dbuf_d, addr_q, addr_d, data_q, data_d;
    logic ibuf_q, ibuf_d, imem_q, imem_d, debug_q, debug_d, we_q, we_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = START;
            end
            START: if (cnt_q == HALF_END) begin
                cnt_d      = '0;
                bit_d      = '0;
                rx_state_d = rx_sync_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_END) begin
                cnt_d   = '0;
                shift_d = {rx_sync_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) rx_state_d = STOP;
            end
            STOP: if (cnt_q == BIT_END) begin
                cnt_d      = '0;
                rx_state_d = IDLE;
                byte_valid = rx_sync_q;
                frame_err  = !rx_sync_q;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_comb begin
        p_state_d = p_state_q;
        idx_d     = idx_q;
        abuf_d    = abuf_q;
        dbuf_d    = dbuf_q;
        ibuf_d    = ibuf_q;
        addr_d    = addr_q;
        data_d    = data_q;
        imem_d    = imem_q;
        debug_d   = debug_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        // The idle timer only advances between bytes; a byte in flight freezes it.
        tmo_d = (p_state_q == P_CMD || byte_valid) ? '0 :
                (rx_state_q == IDLE) ? tmo_q + TW'(1) : tmo_q;
        if (frame_err) begin
            err_d     = 1'b1;
            p_state_d = P_CMD;
        end else if (tmo_q == TMO) begin
            err_d     = 1'b1;
            p_state_d = P_CMD;
            tmo_d     = '0;
        end else if (byte_valid) begin
            case (p_state_q)
                P_CMD: if (shift_q == 8'hA5 || shift_q == 8'h5A) begin
                    ibuf_d    = shift_q == 8'hA5;
                    debug_d   = 1'b1;
                    idx_d     = '0;
                    p_state_d = P_ADDR;
                end else if (shift_q == 8'hC3) debug_d = 1'b0;
                else err_d = 1'b1;
                P_ADDR: begin
                    abuf_d[{idx_q, 3'b000} +: 8] = shift_q;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) p_state_d = P_DATA;
                end
                P_DATA: begin
                    dbuf_d[{idx_q, 3'b000} +: 8] = shift_q;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        p_state_d = P_CMD;
                        we_d      = 1'b1;
                        addr_d    = abuf_q;
                        data_d    = {shift_q, dbuf_q[23:0]};
                        imem_d    = ibuf_q;
                    end
                end
                default: p_state_d = P_CMD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            p_state_q  <= P_CMD;
            idx_q      <= '0;
            abuf_q     <= '0;
            dbuf_q     <= '0;
            ibuf_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            imem_q     <= 1'b0;
            debug_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            p_state_q  <= p_state_d;
            idx_q      <= idx_d;
            abuf_q     <= abuf_d;
            dbuf_q     <= dbuf_d;
            ibuf_q     <= ibuf_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            imem_q     <= imem_d;
            debug_q    <= debug_d;
            we_q       <= we_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign debug_o      = debug_q;
    assign debug_addr_o = addr_q;
    assign debug_data_o = data_q;
    assign debug_imem_o = imem_q;
    assign debug_we_o   = we_q;
    assign rx_err_o     = err_q;
endmodule

// File: tb/tb_uart_debug_loader.sv
// tb_uart_debug_loader: serial-frame scoreboard bench for uart_debug_loader.
module tb_uart_debug_loader;
    localparam int CPB = 16;
    localparam int TMO = 2000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        im;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_i = 1'b1;
    logic debug_o, debug_imem_o, debug_we_o, rx_err_o;
    logic [31:0] debug_addr_o, debug_data_o;

    wr_t exp_q[$];
    wr_t mon_e;
    int pass_cnt = 0;
    int total_cnt = 0;
    int err_cnt = 0;
    int err0;

    uart_debug_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .rx_i(rx_i),
        .debug_o(debug_o),
        .debug_addr_o(debug_addr_o),
        .debug_data_o(debug_data_o),
        .debug_imem_o(debug_imem_o),
        .debug_we_o(debug_we_o),
        .rx_err_o(rx_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset) begin
        if (rx_err_o) err_cnt++;
        if (debug_we_o) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected got addr=%h data=%h imem=%b, required no strobe",
                         debug_addr_o, debug_data_o, debug_imem_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({debug_addr_o, debug_data_o, debug_imem_o} !== mon_e)
                    $display("FAIL strobe_value got addr=%h data=%h imem=%b, required addr=%h data=%h imem=%b",
                             debug_addr_o, debug_data_o, debug_imem_o, mon_e.a, mon_e.d, mon_e.im);
                else pass_cnt++;
            end
            total_cnt++;
            if (rx_err_o !== 1'b0) $display("FAIL err_with_we got rx_err_o=%b, required 0", rx_err_o);
            else pass_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input int nbits = 10);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_i = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d, cmd == 8'hA5});
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic drain(input string name);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_missing got %0d pending strobes, required 0", name, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        err0 = err_cnt;
        repeat (1000) @(negedge clk);
        total_cnt++;
        if ({debug_o, debug_addr_o, debug_data_o, debug_imem_o, debug_we_o, rx_err_o} !== 68'd0)
            $display("FAIL reset_outputs got debug=%b addr=%h data=%h imem=%b we=%b err=%b, required all 0",
                     debug_o, debug_addr_o, debug_data_o, debug_imem_o, debug_we_o, rx_err_o);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - err0 != 0) $display("FAIL reset_err got %0d errors, required 0", err_cnt - err0);
        else pass_cnt++;
    endtask

    task automatic test_imem_write();
        logic [31:0] a, d;
        a = 32'h10;
        d = 32'h513;
        err0 = err_cnt;
        exp_q.push_back({a, d, 1'b1});
        send_byte(8'hA5);
        total_cnt++;
        if (debug_o !== 1'b1) $display("FAIL imem_debug_set got %b, required 1", debug_o);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        drain("imem");
        total_cnt++;
        if ({debug_addr_o, debug_data_o, debug_imem_o} !== {a, d, 1'b1})
            $display("FAIL imem_hold got addr=%h data=%h imem=%b, required %h %h 1",
                     debug_addr_o, debug_data_o, debug_imem_o, a, d);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - err0 != 0) $display("FAIL imem_err got %0d errors, required 0", err_cnt - err0);
        else pass_cnt++;
    endtask

    task automatic test_dmem_write();
        err0 = err_cnt;
        send_frame(8'h5A, 32'h4, 32'hDEADBEEF);
        drain("dmem");
        total_cnt++;
        if (debug_o !== 1'b1) $display("FAIL dmem_debug got %b, required 1", debug_o);
        else pass_cnt++;
        send_byte(8'hC3);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (debug_o !== 1'b0) $display("FAIL release_debug got %b, required 0", debug_o);
        else pass_cnt++;
        total_cnt++;
        if ({debug_addr_o, debug_data_o, debug_imem_o} !== {32'h4, 32'hDEADBEEF, 1'b0})
            $display("FAIL release_hold got addr=%h data=%h imem=%b, required 4 deadbeef 0",
                     debug_addr_o, debug_data_o, debug_imem_o);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - err0 != 0) $display("FAIL dmem_err got %0d errors, required 0", err_cnt - err0);
        else pass_cnt++;
    endtask

    task automatic test_glitch_framing();
        err0 = err_cnt;
        rx_i = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx_i = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total_cnt++;
        if (err_cnt - err0 != 0) $display("FAIL glitch_err got %0d errors, required 0", err_cnt - err0);
        else pass_cnt++;
        send_byte(8'h5A, 1'b0);
        rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        total_cnt++;
        if (err_cnt - err0 != 1) $display("FAIL framing_err got %0d errors, required 1", err_cnt - err0);
        else pass_cnt++;
        total_cnt++;
        if (debug_o !== 1'b0) $display("FAIL framing_debug got %b, required 0", debug_o);
        else pass_cnt++;
        send_frame(8'h5A, 32'h0000_0100, 32'h1234_5678);
        drain("after_framing");
    endtask

    task automatic test_bad_cmd_timeout();
        err0 = err_cnt;
        send_byte(8'h77);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (err_cnt - err0 != 1) $display("FAIL badcmd_err got %0d errors, required 1", err_cnt - err0);
        else pass_cnt++;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (TMO + 200) @(negedge clk);
        total_cnt++;
        if (err_cnt - err0 != 2) $display("FAIL timeout_err got %0d errors, required 2", err_cnt - err0);
        else pass_cnt++;
        total_cnt++;
        if ({debug_o, debug_addr_o, debug_data_o} !== {1'b1, 32'h0000_0100, 32'h1234_5678})
            $display("FAIL timeout_hold got debug=%b addr=%h data=%h, required 1 00000100 12345678",
                     debug_o, debug_addr_o, debug_data_o);
        else pass_cnt++;
        send_frame(8'hA5, 32'h8000_0020, 32'hCAFE_F00D);
        drain("after_timeout");
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        send_byte(8'h11);
        send_byte(8'h22, 1'b1, 5);
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({debug_o, debug_addr_o, debug_data_o, debug_imem_o, debug_we_o, rx_err_o} !== 68'd0)
            $display("FAIL midreset_outputs got debug=%b addr=%h data=%h imem=%b we=%b err=%b, required all 0",
                     debug_o, debug_addr_o, debug_data_o, debug_imem_o, debug_we_o, rx_err_o);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        reset = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        err0 = err_cnt;
        send_frame(8'h5A, 32'h0000_0ABC, 32'h0BAD_C0DE);
        drain("after_reset");
        total_cnt++;
        if (err_cnt - err0 != 0) $display("FAIL after_reset_err got %0d errors, required 0", err_cnt - err0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_imem_write();
        test_dmem_write();
        test_glitch_framing();
        test_bad_cmd_timeout();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_debug_loader.md
Name: uart_debug_loader

Overview:
- UART receiver plus frame decoder: the receive-side counterpart of the core's UART `tx` output.
- Turns a host byte stream into word writes on the top-level debug interface (hold/halt, address, data, imem select).
- Lets a host load IMEM/DMEM over the serial line and release the core without reprogramming the FPGA.
- Sits between the board RX pin and the debug inputs of the top level.

Parameters:
CLKS_PER_BIT, 174, clock cycles per UART bit (20 MHz / 115200); minimum 4
TIMEOUT_CLKS, 1_000_000, maximum idle clocks allowed between bytes inside one frame before the frame is aborted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
rx_i  in  1  UART serial input; idle high; 8N1; LSB first
debug_o  out  1  1 = core held in debug/load mode
debug_addr_o  out  32  byte address of current write
debug_data_o  out  32  write data word
debug_imem_o  out  1  1 = write targets IMEM, 0 = DMEM
debug_we_o  out  1  one-cycle write strobe; addr/data/imem valid in the same cycle
rx_err_o  out  1  one-cycle pulse on framing error, unknown command or timeout

Behaviour:
- Reset values (while reset=0): all outputs 0; RX FSM in IDLE; parser in P_CMD; internal counters 0.
- rx_i passes through a 2-FF synchronizer with reset value 1. All sampling uses the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START: wait CLKS_PER_BIT/2 (integer division), then sample. If 1, this is a false start: back to IDLE, no error. If 0, go to DATA.
  - DATA: sample 8 bits, each CLKS_PER_BIT after the previous sample, LSB first.
  - STOP: sample after CLKS_PER_BIT. If 1, emit an internal byte_valid for 1 cycle. If 0, pulse rx_err_o, discard the byte and reset the parser to P_CMD.
  - From STOP, return to IDLE immediately after the sample. The next start edge is accepted from the following cycle.
- Parser states: P_CMD, P_ADDR (index 0..3), P_DATA (index 0..3). Each state consumes exactly one byte per byte_valid.
- Commands accepted in P_CMD:
  - 0xA5: IMEM write; latch imem=1; debug_o<=1; go to P_ADDR.
  - 0x5A: DMEM write; latch imem=0; debug_o<=1; go to P_ADDR.
  - 0xC3: debug_o<=0; stay in P_CMD; no write strobe.
  - Any other byte: pulse rx_err_o; stay in P_CMD.
- Address and data are each 4 bytes, little-endian: byte k goes to bits [8k+7:8k].
- After the 4th data byte, debug_we_o=1 for exactly one cycle, in the cycle after that byte's byte_valid. Parser then returns to P_CMD.
- debug_addr_o, debug_data_o and debug_imem_o update only in the strobe cycle. They hold their values until the next completed write; a partial frame never changes them.
- Timeout:
  - An idle counter runs while the parser is not in P_CMD and the RX FSM is in IDLE.
  - The counter clears on every byte_valid.
  - When it reaches TIMEOUT_CLKS: pulse rx_err_o, return to P_CMD, keep debug_o unchanged.
- Simultaneous events:
  - A framing error on the last data byte produces no strobe.
  - rx_err_o and debug_we_o are never high in the same cycle.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is lost. The first byte after release is treated as a command.
- No flow control; bytes arriving while a strobe is issued are not lost (strobe takes 1 cycle, well below one bit time).

Test Plan:
- Reset then idle rx_i=1 for 1000 clks -> all outputs 0, no rx_err_o.
- Send A5 10 00 00 00 13 05 00 00 -> debug_o=1 after first byte; one debug_we_o pulse with addr=0x00000010, data=0x00000513, imem=1; no rx_err_o.
- Send 5A 04 00 00 00 EF BE AD DE, then C3 -> strobe with addr=0x4, data=0xDEADBEEF, imem=0; after C3, debug_o=0.
- Glitch: rx_i low for CLKS_PER_BIT/4 clocks -> no byte, no rx_err_o. Then a byte 0x5A with stop bit forced 0 -> rx_err_o pulse, parser stays in P_CMD.
- Send 0x77 -> rx_err_o pulse, no strobe. Send A5 01 02, then idle past TIMEOUT_CLKS -> rx_err_o pulse, debug_o stays 1, addr/data unchanged. A following full A5 frame writes correctly.
- Assert reset=0 during data byte 2 of an A5 frame -> all outputs 0 at once. After release, a full 5A frame strobes correctly.
